// File: rtl/mem_pkg.sv
// Shared constants and types for clients of the single-port word memory.
// Word address is [15:1] of the byte address; read data arrives a fixed latency after the address.
package mem_pkg;
    localparam int MEM_AW     = 15;
    localparam int MEM_DW     = 16;
    localparam int MEM_RD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count; head word is visible on o_pop_dat.
// Latency: a word pushed at an edge is readable in the next cycle.
// Backpressure: none internally; the caller must never push when full without popping.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_dat,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
endmodule

// File: rtl/mem_stream_reader.sv
// Streams count sequential words from base out of the memory read port onto a valid/ready output.
// Latency: start cycle + issue cycle + MEM_RD_LAT read cycles, so first out_valid 4 cycles after start.
// Backpressure: reads are issued only while FIFO occupancy plus in-flight reads leave a free slot.
module mem_stream_reader
    import mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_RD_LAT = mem_pkg::MEM_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MEM_AW-1:0] base,
    input  logic [15:0]       count,
    output logic              busy,
    output logic              done,
    output logic [MEM_AW-1:0] mem_raddr,
    input  logic [MEM_DW-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MEM_DW-1:0] out_data
);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int ICW = $clog2(MEM_RD_LAT + 1);

    state_e                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [MEM_AW-1:0]     r_raddr;
    logic [15:0]           r_remaining;
    logic [MEM_RD_LAT-1:0] r_inflight;

    logic [FCW-1:0] w_fifo_count;
    logic           w_fifo_empty;
    logic           w_fifo_full;
    logic [ICW-1:0] w_inflight_cnt;
    logic [7:0]     w_credit_used;
    logic           w_issue;
    logic           w_push;
    logic           w_pop;
    logic           w_last_pop;

    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < MEM_RD_LAT; i++) begin
            w_inflight_cnt = w_inflight_cnt + ICW'(r_inflight[i]);
        end
    end

    // Every in-flight read already owns a FIFO slot, so returning data can never overflow.
    assign w_credit_used = 8'(w_fifo_count) + 8'(w_inflight_cnt);
    assign w_issue       = (r_state == ISSUE) && (r_remaining != 16'd0) && !w_fifo_full
                           && (w_credit_used < 8'(FIFO_DEPTH));
    assign w_push        = r_inflight[MEM_RD_LAT-1];
    assign w_pop         = out_valid && out_ready;
    assign w_last_pop    = (r_state == DRAIN) && (w_inflight_cnt == '0)
                           && (w_fifo_count == FCW'(1)) && w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= {r_inflight[MEM_RD_LAT-2:0], w_issue};
        end
    end

    // done is registered: it rises the cycle after the final handshake, together with busy falling.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_raddr     <= '0;
            r_remaining <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (count != 16'd0) begin
                            r_state     <= ISSUE;
                            r_busy      <= 1'b1;
                            r_raddr     <= base;
                            r_remaining <= count;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_raddr     <= r_raddr + 1'b1;
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (MEM_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (mem_rdata),
        .i_pop      (w_pop),
        .o_pop_dat  (out_data),
        .o_count    (w_fifo_count),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full)
    );

    assign out_valid = !w_fifo_empty;
    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_raddr = r_raddr;
endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a 2-cycle-latency word memory model.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_stream_reader;
    logic        clk;
    logic        reset;
    logic        start;
    logic [14:0] base;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:32767];
    logic [15:0] rd_p1;
    logic [15:0] rd_p2;
    logic [15:0] exp_q [$];

    mem_stream_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_p1 <= mem[mem_raddr];
        rd_p2 <= rd_p1;
    end
    assign mem_rdata = rd_p2;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic collect(input string tag, input int budget);
        int dones = 0;
        for (int c = 0; c < budget; c++) begin
            if (done) dones++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk({tag, "_extra"}, 32'(out_valid), 32'd0);
                else                   chk({tag, "_word"}, 32'(out_data), 32'(exp_q.pop_front()));
            end
            step();
        end
        chk({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_done_cnt"}, 32'(dones), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    logic [14:0] t1_raddr [8] = '{15'h100, 15'h101, 15'h102, 15'h103,
                                  15'h104, 15'h104, 15'h104, 15'h104};
    logic        t1_busy  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic        t1_vld   [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    logic [15:0] t1_dat   [8] = '{16'h0, 16'h0, 16'h0, 16'hA0A0,
                                  16'hA1A1, 16'hA2A2, 16'hA3A3, 16'h0};

    initial begin
        for (int a = 0; a < 32768; a++) mem[a] = 16'(a) ^ 16'hC3C3;
        mem[15'h100] = 16'hA0A0; mem[15'h101] = 16'hA1A1;
        mem[15'h102] = 16'hA2A2; mem[15'h103] = 16'hA3A3;
        for (int i = 0; i < 10; i++) mem[15'h200 + i] = 16'hB200 + 16'(i);
        mem[15'h7FFE] = 16'h7E7E; mem[15'h7FFF] = 16'h7F7F;
        mem[15'h0000] = 16'h0A00; mem[15'h0001] = 16'h0A01;
        mem[15'h300]  = 16'h3300; mem[15'h301]  = 16'h3301;
        for (int i = 0; i < 8; i++) mem[15'h400 + i] = 16'hD400 + 16'(i);
        for (int i = 0; i < 5; i++) mem[15'h500 + i] = 16'hE500 + 16'(i);
        for (int i = 0; i < 5; i++) mem[15'h600 + i] = 16'hE600 + 16'(i);

        reset = 1'b1; start = 1'b0; base = '0; count = '0; out_ready = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_raddr", 32'(mem_raddr), 32'd0);
        reset = 1'b0;
        step();

        // Basic 4-word read, cycle-exact.
        base = 15'h100; count = 16'd4; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("t1_raddr", 32'(mem_raddr), 32'(t1_raddr[k]));
            chk("t1_busy", 32'(busy), 32'(t1_busy[k]));
            chk("t1_vld", 32'(out_valid), 32'(t1_vld[k]));
            if (t1_vld[k]) chk("t1_data", 32'(out_data), 32'(t1_dat[k]));
            chk("t1_done", 32'(done), (k == 7) ? 32'd1 : 32'd0);
            step();
        end
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Backpressure: only FIFO_DEPTH reads may be outstanding.
        base = 15'h200; count = 16'd10; out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        chk("bp_raddr_stall", 32'(mem_raddr), 32'h204);
        chk("bp_vld", 32'(out_valid), 32'd1);
        chk("bp_head", 32'(out_data), 32'hB200);
        chk("bp_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) exp_q.push_back(16'hB200 + 16'(i));
        out_ready = 1'b1;
        collect("bp", 40);

        // Zero-length request.
        base = 15'h123; count = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("z_done", 32'(done), 32'd1);
        chk("z_busy", 32'(busy), 32'd0);
        chk("z_vld", 32'(out_valid), 32'd0);
        chk("z_raddr", 32'(mem_raddr), 32'h20A);
        step();
        chk("z_done_low", 32'(done), 32'd0);
        chk("z_busy2", 32'(busy), 32'd0);
        chk("z_vld2", 32'(out_valid), 32'd0);

        // Address wrap at the top of the word space.
        base = 15'h7FFE; count = 16'd4; start = 1'b1;
        step();
        start = 1'b0;
        chk("wrap_a0", 32'(mem_raddr), 32'h7FFE);
        step();
        chk("wrap_a1", 32'(mem_raddr), 32'h7FFF);
        step();
        chk("wrap_a2", 32'(mem_raddr), 32'h0000);
        step();
        chk("wrap_a3", 32'(mem_raddr), 32'h0001);
        exp_q.push_back(16'h7E7E); exp_q.push_back(16'h7F7F);
        exp_q.push_back(16'h0A00); exp_q.push_back(16'h0A01);
        collect("wrap", 20);

        // Reset while reads are in flight.
        base = 15'h400; count = 16'd8; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_vld", 32'(out_valid), 32'd0);
        chk("mr_data", 32'(out_data), 32'd0);
        chk("mr_raddr", 32'(mem_raddr), 32'd0);
        reset = 1'b0;
        begin
            int ghost = 0;
            for (int c = 0; c < 8; c++) begin
                if (out_valid) ghost++;
                step();
            end
            chk("mr_ghost_words", 32'(ghost), 32'd0);
        end
        base = 15'h300; count = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        exp_q.push_back(16'h3300); exp_q.push_back(16'h3301);
        collect("post_rst", 15);

        // A start while busy must be ignored.
        base = 15'h500; count = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        base = 15'h600; count = 16'd5; start = 1'b1;
        chk("bs_busy", 32'(busy), 32'd1);
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(16'hE500 + 16'(i));
        collect("busy_start", 20);
        chk("bs_raddr_end", 32'(mem_raddr), 32'h503);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
